// File: rtl/nf_dm_resp.sv
// Data-bus responder: word RAM plus a memory-mapped compare timer with interrupt.
// Reads are combinational on addr_dm; writes commit on the rising edge; no backpressure.
// Optional NF_DM_RESP_ERR_EN adds a sticky unmapped-write flag with fault address capture.
module nf_dm_resp #(
  parameter int          DEPTH    = 64,
  parameter logic [31:0] PER_BASE = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr_dm,
  input  logic        we_dm,
  input  logic [31:0] wd_dm,
  output logic [31:0] rd_dm,
  output logic        irq,
  output logic        err
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

  typedef enum logic [1:0] {IDLE, RUN, HALT} tmr_state_t;

  tmr_state_t  state_q, state_d;
  logic [2:0]  ctrl_q;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] cmp_q;
  logic        hit_q, hit_d;
  logic        run_act, hit_evt;
  logic [31:0] erraddr_val;

  logic [31:0] mem [DEPTH];

  // Byte lanes are not decoded; the low address bits only matter for ERRADDR capture.
  logic [31:0] word_addr;
  logic        unused_low_bits;
  assign word_addr       = {addr_dm[31:2], 2'b00};
  assign unused_low_bits = &{1'b0, addr_dm[1:0]};

  logic sel_ram, sel_ctrl, sel_cnt, sel_cmp, sel_status, sel_erraddr;
  assign sel_ram     = word_addr < RAM_BYTES;
  assign sel_ctrl    = word_addr == PER_BASE;
  assign sel_cnt     = word_addr == PER_BASE + 32'h4;
  assign sel_cmp     = word_addr == PER_BASE + 32'h8;
  assign sel_status  = word_addr == PER_BASE + 32'hC;
  assign sel_erraddr = word_addr == PER_BASE + 32'h10;

  logic wr_ctrl, wr_cnt, wr_cmp, wr_status;
  assign wr_ctrl   = we_dm & sel_ctrl;
  assign wr_cnt    = we_dm & sel_cnt;
  assign wr_cmp    = we_dm & sel_cmp;
  assign wr_status = we_dm & sel_status;

  always_ff @(posedge clk) begin
    if (we_dm && sel_ram) mem[addr_dm[AW+1:2]] <= wd_dm;
  end

  // A CTRL write clearing en stops the counter on that same edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hit_d   = hit_q;
    run_act = (state_q == RUN) && !(wr_ctrl && !wd_dm[0]);
    hit_evt = run_act && (cnt_q == cmp_q);

    if (run_act) begin
      if (hit_evt) begin
        if (ctrl_q[1]) cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end
    if (wr_cnt) cnt_d = wd_dm;

    if (wr_status && wd_dm[0]) hit_d = 1'b0;
    if (hit_evt)               hit_d = 1'b1;

    case (state_q)
      IDLE:    if (wr_ctrl && wd_dm[0]) state_d = RUN;
      RUN:     if (hit_evt && !ctrl_q[1]) state_d = HALT;
      HALT:    if ((wr_cnt && ctrl_q[0]) || (wr_ctrl && wd_dm[0])) state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (wr_ctrl && !wd_dm[0]) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
      cnt_q   <= '0;
      cmp_q   <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      if (wr_ctrl) ctrl_q <= wd_dm[2:0];
      if (wr_cmp)  cmp_q  <= wd_dm;
    end
  end

`ifdef NF_DM_RESP_ERR_EN
  logic        err_q;
  logic [31:0] erraddr_q;
  logic        unmapped;
  assign unmapped = !(sel_ram | sel_ctrl | sel_cnt | sel_cmp | sel_status | sel_erraddr);

  // Only the first fault address is kept until software clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q     <= 1'b0;
      erraddr_q <= '0;
    end else if (we_dm && sel_erraddr) begin
      err_q     <= 1'b0;
      erraddr_q <= '0;
    end else if (we_dm && unmapped) begin
      err_q <= 1'b1;
      if (!err_q) erraddr_q <= addr_dm;
    end
  end
  assign err         = err_q;
  assign erraddr_val = erraddr_q;
`else
  assign err         = 1'b0;
  assign erraddr_val = '0;
`endif

  always_comb begin
    rd_dm = '0;
    if (sel_ram)          rd_dm = mem[addr_dm[AW+1:2]];
    else if (sel_ctrl)    rd_dm = {29'd0, ctrl_q};
    else if (sel_cnt)     rd_dm = cnt_q;
    else if (sel_cmp)     rd_dm = cmp_q;
    else if (sel_status)  rd_dm = {31'd0, hit_q};
    else if (sel_erraddr) rd_dm = erraddr_val;
  end

  assign irq = hit_q & ctrl_q[2];

endmodule

// File: tb/tb_nf_dm_resp.sv
// Bench for nf_dm_resp: register/RAM vector table, timer corner sequences, randomized model compare.
module tb_nf_dm_resp;

  localparam logic [31:0] PB      = 32'h0001_0000;
  localparam logic [31:0] A_CTRL  = PB;
  localparam logic [31:0] A_CNT   = PB + 32'h4;
  localparam logic [31:0] A_CMP   = PB + 32'h8;
  localparam logic [31:0] A_STAT  = PB + 32'hC;
  localparam logic [31:0] A_EADDR = PB + 32'h10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr_dm;
  logic        we_dm;
  logic [31:0] wd_dm;
  logic [31:0] rd_dm;
  logic        irq;
  logic        err;

  int checks = 0;
  int errors = 0;

  nf_dm_resp #(.DEPTH(64), .PER_BASE(PB)) dut (
    .clk(clk), .reset(reset), .addr_dm(addr_dm), .we_dm(we_dm),
    .wd_dm(wd_dm), .rd_dm(rd_dm), .irq(irq), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic peek(input logic [31:0] a, input logic [31:0] exp, input string name);
    addr_dm = a;
    we_dm   = 1'b0;
    #1;
    check(name, rd_dm, exp);
  endtask

  task automatic chk_irq(input bit exp, input string name);
    check(name, {31'd0, irq}, {31'd0, exp});
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr_dm = a;
    wd_dm   = d;
    we_dm   = 1'b1;
    @(posedge clk);
    #1;
    we_dm = 1'b0;
  endtask

  task automatic tick();
    we_dm = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    we_dm = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_ram [logic [31:0]];
  logic [2:0]  m_ctrl;
  logic [31:0] m_cnt, m_cmp, m_eaddr;
  bit          m_hit, m_counting, m_halted, m_err;

  task automatic model_reset();
    m_ctrl = '0; m_cnt = '0; m_cmp = '0; m_eaddr = '0;
    m_hit = 0; m_counting = 0; m_halted = 0; m_err = 0;
  endtask

  // 0 RAM, 1 CTRL, 2 CNT, 3 CMP, 4 STATUS, 5 ERRADDR, 6 unmapped
  function automatic int region(input logic [31:0] a);
    logic [31:0] w;
    w = a & ~32'h3;
    if (w < 32'd256) return 0;
    if (w >= PB && w <= PB + 32'h10) return int'((w - PB) >> 2) + 1;
    return 6;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    logic [31:0] w;
    w = a & ~32'h3;
    case (region(a))
      0: return m_ram.exists(w) ? m_ram[w] : 32'hx;
      1: return {29'd0, m_ctrl};
      2: return m_cnt;
      3: return m_cmp;
      4: return {31'd0, m_hit};
`ifdef NF_DM_RESP_ERR_EN
      5: return m_eaddr;
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step(input bit we, input logic [31:0] a, input logic [31:0] d);
    int r;
    bit wc, wcnt, wstat, counting_now, hit, ncount, nhalt, nh;
    logic [31:0] nc;
    r = region(a);
    wc = we && r == 1; wcnt = we && r == 2; wstat = we && r == 4;
    counting_now = m_counting && !(wc && !d[0]);
    hit = counting_now && (m_cnt == m_cmp);
    nc = m_cnt;
    if (counting_now) nc = hit ? (m_ctrl[1] ? 32'd0 : m_cnt) : m_cnt + 32'd1;
    if (wcnt) nc = d;
    nh = m_hit;
    if (wstat && d[0]) nh = 0;
    if (hit) nh = 1;
    ncount = m_counting; nhalt = m_halted;
    if (hit && !m_ctrl[1]) begin ncount = 0; nhalt = 1; end
    if (m_halted && ((wcnt && m_ctrl[0]) || (wc && d[0]))) begin ncount = 1; nhalt = 0; end
    if (wc && d[0] && !m_counting) begin ncount = 1; nhalt = 0; end
    if (wc && !d[0]) begin ncount = 0; nhalt = 0; end
`ifdef NF_DM_RESP_ERR_EN
    if (we && r == 5) begin
      m_err = 0; m_eaddr = '0;
    end else if (we && r == 6) begin
      if (!m_err) m_eaddr = a;
      m_err = 1;
    end
`endif
    if (we && r == 0) m_ram[a & ~32'h3] = d;
    if (wc) m_ctrl = d[2:0];
    if (we && r == 3) m_cmp = d;
    m_cnt = nc; m_hit = nh; m_counting = ncount; m_halted = nhalt;
  endtask

  task automatic rstep(input bit we, input logic [31:0] a, input logic [31:0] d, input bit cmp_en);
    addr_dm = a; wd_dm = d; we_dm = we;
    #1;
    if (cmp_en) begin
      check("rnd_rd", rd_dm, model_rd(a));
      check("rnd_irq", {31'd0, irq}, {31'd0, m_hit & m_ctrl[2]});
      check("rnd_err", {31'd0, err}, {31'd0, m_err});
    end
    @(posedge clk);
    model_step(we, a, d);
    #1;
    we_dm = 1'b0;
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] lo;
    lo = 32'($urandom_range(0, 3));
    case ($urandom_range(0, 9))
      0, 1, 2, 3: return 32'($urandom_range(0, 63)) * 4 + lo;
      4, 5, 6:    return PB + 32'($urandom_range(0, 5)) * 4 + lo;
      7:          return 32'h100 + lo;
      8:          return 32'h0002_0000 + lo;
      default:    return PB - 32'h4 + lo;
    endcase
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wd;
    bit          chk;
    logic [31:0] exp_rd;
    bit          exp_irq;
  } vec_t;

  vec_t vt[$];

  task automatic add(input bit we, input logic [31:0] a, input logic [31:0] d,
                     input bit chk, input logic [31:0] e, input bit ei);
    vec_t v;
    v.we = we; v.addr = a; v.wd = d; v.chk = chk; v.exp_rd = e; v.exp_irq = ei;
    vt.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; we_dm = 1'b0; addr_dm = '0; wd_dm = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset state
    peek(A_CTRL, 32'd0, "rst_ctrl");
    peek(A_CNT, 32'd0, "rst_cnt");
    peek(A_CMP, 32'd0, "rst_cmp");
    peek(A_STAT, 32'd0, "rst_status");
    chk_irq(0, "rst_irq");
    check("rst_err", {31'd0, err}, 32'd0);

    // exp_rd is the read value seen before the row's edge
    add(0, A_EADDR,      32'd0,        1, 32'd0,        0);
    add(1, 32'h14,       32'h12345678, 0, 32'd0,        0);
    add(1, 32'h10,       32'hDEADBEEF, 0, 32'd0,        0);
    add(0, 32'h10,       32'd0,        1, 32'hDEADBEEF, 0);
    add(0, 32'h14,       32'd0,        1, 32'h12345678, 0);
    add(0, 32'h13,       32'd0,        1, 32'hDEADBEEF, 0);
    add(1, A_CMP,        32'hA5A50001, 1, 32'd0,        0);
    add(0, A_CMP,        32'd0,        1, 32'hA5A50001, 0);
    add(1, A_CNT,        32'd7,        1, 32'd0,        0);
    add(0, A_CNT,        32'd0,        1, 32'd7,        0);
    add(0, A_CNT,        32'd0,        1, 32'd7,        0);
    add(1, A_CTRL,       32'd4,        1, 32'd0,        0);
    add(0, A_CTRL,       32'd0,        1, 32'd4,        0);
    add(0, A_CNT,        32'd0,        1, 32'd7,        0);
    add(1, A_STAT,       32'd1,        1, 32'd0,        0);
    add(0, A_STAT,       32'd0,        1, 32'd0,        0);
    add(1, 32'h0,        32'h11111111, 0, 32'd0,        0);
    add(1, 32'h100,      32'h1,        1, 32'd0,        0);
    add(0, 32'h100,      32'd0,        1, 32'd0,        0);
    add(0, 32'h0,        32'd0,        1, 32'h11111111, 0);
    add(0, 32'h0002_0000,32'd0,        1, 32'd0,        0);
    add(1, PB + 32'h14,  32'hFFFF,     1, 32'd0,        0);
    add(0, PB + 32'h14,  32'd0,        1, 32'd0,        0);
    add(1, A_CTRL,       32'd0,        1, 32'd4,        0);
    add(0, A_CTRL,       32'd0,        1, 32'd0,        0);

    for (int i = 0; i < vt.size(); i++) begin
      addr_dm = vt[i].addr; wd_dm = vt[i].wd; we_dm = vt[i].we;
      #1;
      if (vt[i].chk) check($sformatf("vec%0d_rd", i), rd_dm, vt[i].exp_rd);
      chk_irq(vt[i].exp_irq, $sformatf("vec%0d_irq", i));
      @(posedge clk);
      #1;
      we_dm = 1'b0;
    end

    // one-shot
    do_reset();
    wr(A_CMP, 32'd5);
    wr(A_CTRL, 32'd5);
    peek(A_CNT, 32'd0, "os_cnt0");
    for (int k = 1; k <= 5; k++) begin
      tick();
      peek(A_CNT, 32'(k), $sformatf("os_cnt%0d", k));
      peek(A_STAT, 32'd0, $sformatf("os_stat%0d", k));
      chk_irq(0, $sformatf("os_irq%0d", k));
    end
    tick();
    peek(A_STAT, 32'd1, "os_hit_stat");
    peek(A_CNT, 32'd5, "os_hit_cnt");
    chk_irq(1, "os_hit_irq");
    tick(); tick();
    peek(A_CNT, 32'd5, "os_halt_cnt");
    chk_irq(1, "os_halt_irq");
    wr(A_CNT, 32'd0);
    peek(A_CNT, 32'd0, "os_rearm_cnt");
    tick();
    peek(A_CNT, 32'd1, "os_rerun_cnt");
    wr(A_STAT, 32'd1);
    peek(A_STAT, 32'd0, "os_w1c_stat");
    chk_irq(0, "os_w1c_irq");
    wr(A_CTRL, 32'd0);
    tick();
    peek(A_CNT, 32'd2, "os_idle_cnt");

    // auto-reload and collisions
    do_reset();
    wr(A_CMP, 32'd3);
    wr(A_CTRL, 32'd7);
    peek(A_CNT, 32'd0, "ar_cnt0");
    for (int k = 1; k <= 7; k++) begin
      tick();
      peek(A_CNT, 32'(k % 4), $sformatf("ar_cnt%0d", k));
      chk_irq(k >= 4, $sformatf("ar_irq%0d", k));
    end
    wr(A_STAT, 32'd1);
    peek(A_STAT, 32'd1, "col_w1c_hit_stat");
    peek(A_CNT, 32'd0, "col_reload_cnt");
    chk_irq(1, "col_irq");
    wr(A_STAT, 32'd1);
    peek(A_STAT, 32'd0, "ar_w1c_stat");
    chk_irq(0, "ar_w1c_irq");
    wr(A_CNT, 32'h100);
    peek(A_CNT, 32'h100, "col_cnt_write");
    tick();
    peek(A_CNT, 32'h101, "col_cnt_inc");
    wr(A_CTRL, 32'd0);
    tick();
    peek(A_CNT, 32'h101, "ar_stop_cnt");

    // wrap, then reset mid-run
    do_reset();
    wr(A_CNT, 32'hFFFF_FFFE);
    wr(A_CMP, 32'h10);
    wr(32'h20, 32'hCAFEF00D);
    wr(A_CTRL, 32'd1);
    peek(A_CNT, 32'hFFFF_FFFE, "wr_cnt0");
    tick(); peek(A_CNT, 32'hFFFF_FFFF, "wr_cnt1");
    tick(); peek(A_CNT, 32'd0, "wr_cnt2");
    peek(A_STAT, 32'd0, "wr_nohit");
    tick(); peek(A_CNT, 32'd1, "wr_cnt3");
    wr(A_CMP, 32'd3);
    wr(A_CTRL, 32'd5);
    peek(A_CNT, 32'd3, "wr_pre_hit_cnt");
    tick();
    chk_irq(1, "mid_irq_before_reset");
    do_reset();
    peek(A_CNT, 32'd0, "mid_rst_cnt");
    peek(A_STAT, 32'd0, "mid_rst_stat");
    peek(A_CTRL, 32'd0, "mid_rst_ctrl");
    chk_irq(0, "mid_rst_irq");
    peek(32'h20, 32'hCAFEF00D, "mid_rst_ram20");
    peek(32'h10, 32'hDEADBEEF, "mid_rst_ram10");
    tick();
    peek(A_CNT, 32'd0, "mid_rst_idle_cnt");

    // error capture
    do_reset();
`ifdef NF_DM_RESP_ERR_EN
    wr(32'h0002_0000, 32'd1);
    check("err_set", {31'd0, err}, 32'd1);
    peek(A_EADDR, 32'h0002_0000, "err_addr1");
    wr(32'h0003_0004, 32'd2);
    check("err_sticky", {31'd0, err}, 32'd1);
    peek(A_EADDR, 32'h0002_0000, "err_addr_first");
    wr(A_EADDR, 32'd0);
    check("err_clr", {31'd0, err}, 32'd0);
    peek(A_EADDR, 32'd0, "err_addr_clr");
`else
    wr(32'h0002_0000, 32'd1);
    check("err_tied", {31'd0, err}, 32'd0);
    peek(A_EADDR, 32'd0, "err_addr_zero");
`endif

    // randomized against the model
    do_reset();
    model_reset();
    for (int i = 0; i < 64; i++) rstep(1, 32'(i * 4), $urandom, 0);
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 35)      rstep(0, pick_addr(), $urandom, 1);
      else if (r < 60) rstep(1, 32'($urandom_range(0, 255)), $urandom, 1);
      else if (r < 68) rstep(1, A_CMP + 32'($urandom_range(0, 3)), 32'($urandom_range(0, 12)), 1);
      else if (r < 74) rstep(1, A_CNT, 32'($urandom_range(0, 12)), 1);
      else if (r < 82) rstep(1, A_STAT, $urandom, 1);
      else if (r < 88) rstep(1, A_CTRL, 32'($urandom_range(0, 7)), 1);
      else if (r < 94) rstep(1, pick_addr(), $urandom, 1);
      else             rstep(0, A_CNT, 32'd0, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
